wmem_dist: RTL and testbench

WMEM_DIST -- requirements
Module: wmem_dist

---
 rtl/snn_pkg.sv | 34 +++
 rtl/wmem_pack.sv | 28 ++
 rtl/wmem_dist.sv | 159 +++++++++++++++
 tb/tb_wmem_dist.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared packet-format definitions and FSM state encoding for the SNN weight path.
package snn_pkg;

  localparam int unsigned PKT_WIDTH  = 33;
  localparam int unsigned DEST_LSB   = 29;
  localparam int unsigned DEST_WIDTH = 4;
  localparam int unsigned OP_LSB     = 25;
  localparam int unsigned OP_WIDTH   = 4;
  localparam int unsigned DATA_WIDTH = 25;

  typedef logic [OP_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_WEIGHT       = 4'd0;
  localparam opcode_t OP_WEIGHTS_DONE = 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StNotify
  } wmem_state_e;

  function automatic logic [PKT_WIDTH-1:0] make_pkt(input logic [DEST_WIDTH-1:0] dest,
                                                    input opcode_t op,
                                                    input logic [DATA_WIDTH-1:0] data);
    logic [PKT_WIDTH-1:0] pkt;
    pkt = '0;
    pkt[DEST_LSB +: DEST_WIDTH] = dest;
    pkt[OP_LSB +: OP_WIDTH]     = op;
    pkt[0 +: DATA_WIDTH]        = data;
    return pkt;
  endfunction

endpackage

// File: rtl/wmem_pack.sv
// Combinational packer: selects one chunk of a filter row and packs its weights
// into a packet data field, lowest weight index in the LSBs, unused bits zero.
module wmem_pack
  import snn_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned FILTER_SIZE     = 5,
  parameter int unsigned WEIGHTS_PER_PKT = 3,
  parameter int unsigned CHUNK_WIDTH     = 1
) (
  input  logic [WEIGHT_WIDTH-1:0] row_w [FILTER_SIZE],
  input  logic [CHUNK_WIDTH-1:0]  chunk,
  output logic [DATA_WIDTH-1:0]   data
);

  always_comb begin
    data = '0;
    for (int unsigned k = 0; k < WEIGHTS_PER_PKT; k++) begin
      for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
        // Weights past the row end leave their field at zero.
        if (32'(chunk) * WEIGHTS_PER_PKT + k == c) begin
          data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = row_w[c];
        end
      end
    end
  end

endmodule

// File: rtl/wmem_dist.sv
// Filter-weight store and distributor: loads weights, then streams them row by row
// to consecutive PPEs and notifies IMEM. Optional replay via `WMEM_REPLAY_EN`.
module wmem_dist
  import snn_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned FILTER_SIZE     = 5,
  parameter int unsigned WEIGHTS_PER_PKT = 3,
  parameter int unsigned PPE_BASE        = 5,
  parameter int unsigned IMEM_ID         = 11
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_start,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [$clog2(FILTER_SIZE**2)-1:0]    wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]              wr_data,
  input  logic                                 load_done,
  output logic                                 pkt_valid,
  input  logic                                 pkt_ready,
  output logic [PKT_WIDTH-1:0]                 pkt_data,
  output logic                                 busy,
  output logic                                 dist_done
`ifdef WMEM_REPLAY_EN
  ,
  input  logic                                 ts_valid
`endif
);

  localparam int unsigned NumW       = FILTER_SIZE * FILTER_SIZE;
  localparam int unsigned PktsPerRow = (FILTER_SIZE + WEIGHTS_PER_PKT - 1) / WEIGHTS_PER_PKT;
  localparam int unsigned ChunkWidth = (PktsPerRow > 1) ? $clog2(PktsPerRow) : 1;
  localparam int unsigned RowWidth   = $clog2(FILTER_SIZE + 1);

  logic [WEIGHT_WIDTH-1:0] mem_q [NumW];
  logic [WEIGHT_WIDTH-1:0] row_w [FILTER_SIZE];
  logic [DATA_WIDTH-1:0]   chunk_data;
  logic [DEST_WIDTH-1:0]   row_dest;

  wmem_state_e           state_q;
  logic [RowWidth-1:0]   row_q;
  logic [ChunkWidth-1:0] chunk_q;
  logic                  pkt_valid_q;
  logic [PKT_WIDTH-1:0]  pkt_data_q;
  logic                  dist_done_q;
`ifdef WMEM_REPLAY_EN
  logic                  loaded_q;
`endif

  assign wr_ready  = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign dist_done = dist_done_q;

  // Storage is deliberately not reset so weights survive rst.
  always_ff @(posedge clk) begin
    if (wr_valid && wr_ready && (32'(wr_addr) < NumW)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
      row_w[c] = '0;
    end
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      if (32'(row_q) == r) begin
        for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
          row_w[c] = mem_q[r*FILTER_SIZE + c];
        end
      end
    end
  end

  assign row_dest = DEST_WIDTH'(PPE_BASE + 32'(row_q));

  wmem_pack #(
    .WEIGHT_WIDTH   (WEIGHT_WIDTH),
    .FILTER_SIZE    (FILTER_SIZE),
    .WEIGHTS_PER_PKT(WEIGHTS_PER_PKT),
    .CHUNK_WIDTH    (ChunkWidth)
  ) u_pack (
    .row_w(row_w),
    .chunk(chunk_q),
    .data (chunk_data)
  );

  // row_q/chunk_q index the next packet to present, so a new packet is loaded in
  // the same cycle the previous one is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      chunk_q     <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      dist_done_q <= 1'b0;
`ifdef WMEM_REPLAY_EN
      loaded_q    <= 1'b0;
`endif
    end else begin
      dist_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q <= StLoad;
          end
`ifdef WMEM_REPLAY_EN
          else if (ts_valid && loaded_q) begin
            state_q <= StSend;
            row_q   <= '0;
            chunk_q <= '0;
          end
`endif
        end
        StLoad: begin
          if (load_done) begin
            state_q <= StSend;
            row_q   <= '0;
            chunk_q <= '0;
`ifdef WMEM_REPLAY_EN
            loaded_q <= 1'b1;
`endif
          end
        end
        StSend: begin
          if (!pkt_valid_q || pkt_ready) begin
            if (row_q == RowWidth'(FILTER_SIZE)) begin
              state_q     <= StNotify;
              pkt_valid_q <= 1'b1;
              pkt_data_q  <= make_pkt(DEST_WIDTH'(IMEM_ID), OP_WEIGHTS_DONE, '0);
            end else begin
              pkt_valid_q <= 1'b1;
              pkt_data_q  <= make_pkt(row_dest, OP_WEIGHT, chunk_data);
              if (chunk_q == ChunkWidth'(PktsPerRow - 1)) begin
                chunk_q <= '0;
                row_q   <= row_q + RowWidth'(1);
              end else begin
                chunk_q <= chunk_q + ChunkWidth'(1);
              end
            end
          end
        end
        StNotify: begin
          if (pkt_ready) begin
            state_q     <= StIdle;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            dist_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wmem_dist.sv
// Directed bench for wmem_dist: default instance plus a 3x3 / 2-per-packet instance.
module tb_wmem_dist;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, wr_valid, wr_ready, load_done;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        pkt_valid, pkt_ready, busy, dist_done;
  logic [32:0] pkt_data;
  logic        ts_valid;

  logic        s_load_start, s_wr_valid, s_wr_ready, s_load_done;
  logic [3:0]  s_wr_addr;
  logic [7:0]  s_wr_data;
  logic        s_pkt_valid, s_pkt_ready, s_busy, s_dist_done;
  logic [32:0] s_pkt_data;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tb_mem [25];
  logic [32:0] got_q [$];
  logic [32:0] s_got_q [$];
  int          done_cnt = 0;
  int          s_done_cnt = 0;

  always #5 clk = ~clk;

  wmem_dist dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .load_done (load_done),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .busy      (busy),
    .dist_done (dist_done)
`ifdef WMEM_REPLAY_EN
    ,
    .ts_valid  (ts_valid)
`endif
  );

  wmem_dist #(
    .FILTER_SIZE    (3),
    .WEIGHTS_PER_PKT(2)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .load_start(s_load_start),
    .wr_valid  (s_wr_valid),
    .wr_ready  (s_wr_ready),
    .wr_addr   (s_wr_addr),
    .wr_data   (s_wr_data),
    .load_done (s_load_done),
    .pkt_valid (s_pkt_valid),
    .pkt_ready (s_pkt_ready),
    .pkt_data  (s_pkt_data),
    .busy      (s_busy),
    .dist_done (s_dist_done)
`ifdef WMEM_REPLAY_EN
    ,
    .ts_valid  (1'b0)
`endif
  );

  // Accepted packets and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (pkt_valid && pkt_ready) got_q.push_back(pkt_data);
    if (dist_done) done_cnt++;
    if (s_pkt_valid && s_pkt_ready) s_got_q.push_back(s_pkt_data);
    if (s_dist_done) s_done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] exp_pkt(input int n);
    int row = n / 2;
    int chunk = n % 2;
    logic [24:0] d = '0;
    for (int k = 0; k < 3; k++) begin
      if (chunk * 3 + k < 5) d[k*8 +: 8] = tb_mem[row*5 + chunk*3 + k];
    end
    return {4'(5 + row), 4'd0, d};
  endfunction

  task automatic load_all(input bit merge_last);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_ready got wr_ready=%b busy=%b exp 1 1", wr_ready, busy);
    end
    for (int i = 0; i < 25; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'(i);
      wr_data  = tb_mem[i];
      if (merge_last && i == 24) load_done = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    if (!merge_last) begin
      load_done = 1'b1;
      tick();
    end
    load_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL wait_done got no dist_done within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 5;
    if (pkt_valid !== 1'b0) begin failures++; $display("FAIL rst_pkt_valid got %b exp 0", pkt_valid); end
    if (pkt_data !== 33'd0) begin failures++; $display("FAIL rst_pkt_data got %h exp 0", pkt_data); end
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (dist_done !== 1'b0) begin failures++; $display("FAIL rst_dist_done got %b exp 0", dist_done); end
  endtask

  task automatic check_full_sequence(input string name);
    checks++;
    if (got_q.size() != 11) begin
      failures++;
      $display("FAIL %s_count got %0d exp 11", name, got_q.size());
    end else begin
      for (int n = 0; n < 10; n++) begin
        checks++;
        if (got_q[n] !== exp_pkt(n)) begin
          failures++;
          $display("FAIL %s_pkt%0d got %h exp %h", name, n, got_q[n], exp_pkt(n));
        end
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 25; i++) tb_mem[i] = 8'(i + 1);
    got_q.delete();
    done_cnt  = 0;
    pkt_ready = 1'b1;
    load_all(1'b0);
    checks++;
    if (pkt_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL send_entry got valid=%b busy=%b exp 0 1", pkt_valid, busy);
    end
    tick();
    checks++;
    if (pkt_valid !== 1'b1) begin failures++; $display("FAIL first_valid got %b exp 1", pkt_valid); end
    wait_done(100);
    check_full_sequence("basic");
    checks += 6;
    if (got_q[0] !== {4'd5, 4'd0, 25'h030201}) begin
      failures++; $display("FAIL basic_first got %h exp %h", got_q[0], {4'd5, 4'd0, 25'h030201});
    end
    if (got_q[1] !== {4'd5, 4'd0, 25'h000504}) begin
      failures++; $display("FAIL basic_second got %h exp %h", got_q[1], {4'd5, 4'd0, 25'h000504});
    end
    if (got_q[9] !== {4'd9, 4'd0, 25'h001918}) begin
      failures++; $display("FAIL basic_tenth got %h exp %h", got_q[9], {4'd9, 4'd0, 25'h001918});
    end
    if (got_q[10] !== {4'd11, 4'd0, 25'd0}) begin
      failures++; $display("FAIL basic_notify got %h exp %h", got_q[10], {4'd11, 4'd0, 25'd0});
    end
    if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
  endtask

`ifdef WMEM_REPLAY_EN
  task automatic test_replay_idle();
    got_q.delete();
    ts_valid = 1'b1;
    tick();
    ts_valid = 1'b0;
    repeat (6) tick();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL replay_noload_busy got %b exp 0", busy); end
    if (got_q.size() != 0) begin
      failures++; $display("FAIL replay_noload_pkts got %0d exp 0", got_q.size());
    end
  endtask

  task automatic test_replay();
    got_q.delete();
    done_cnt = 0;
    ts_valid = 1'b1;
    tick();
    ts_valid = 1'b0;
    wait_done(100);
    check_full_sequence("replay");
    checks++;
    if (got_q[10] !== {4'd11, 4'd0, 25'd0}) begin
      failures++; $display("FAIL replay_notify got %h exp %h", got_q[10], {4'd11, 4'd0, 25'd0});
    end
  endtask
`endif

  task automatic test_backpressure();
    int n = 0;
    for (int i = 0; i < 25; i++) tb_mem[i] = 8'(8'hA0 + i);
    got_q.delete();
    done_cnt  = 0;
    pkt_ready = 1'b1;
    load_all(1'b0);
    while (got_q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    pkt_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (pkt_valid !== 1'b1 || pkt_data !== {4'd6, 4'd0, 25'hA7A6A5}) begin
        failures++;
        $display("FAIL stall_hold%0d got valid=%b data=%h exp 1 %h", c, pkt_valid, pkt_data,
                 {4'd6, 4'd0, 25'hA7A6A5});
      end
      tick();
    end
    pkt_ready = 1'b1;
    wait_done(100);
    check_full_sequence("stall");
    checks++;
    if (got_q[3] !== {4'd6, 4'd0, 25'h00A9A8}) begin
      failures++; $display("FAIL stall_pkt3 got %h exp %h", got_q[3], {4'd6, 4'd0, 25'h00A9A8});
    end
  endtask

  task automatic test_same_cycle_done();
    for (int i = 0; i < 24; i++) tb_mem[i] = 8'(i + 1);
    tb_mem[24] = 8'h7F;
    got_q.delete();
    done_cnt  = 0;
    pkt_ready = 1'b1;
    load_all(1'b1);
    wait_done(100);
    check_full_sequence("merge");
    checks++;
    if (got_q[9] !== {4'd9, 4'd0, 25'h007F18}) begin
      failures++; $display("FAIL merge_last got %h exp %h", got_q[9], {4'd9, 4'd0, 25'h007F18});
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    for (int i = 0; i < 25; i++) tb_mem[i] = 8'(i + 1);
    got_q.delete();
    done_cnt  = 0;
    pkt_ready = 1'b1;
    load_all(1'b0);
    while (got_q.size() < 4 && n < 20) begin
      tick();
      n++;
    end
    rst       = 1'b1;
    pkt_ready = 1'b0;
    tick();
    rst = 1'b0;
    checks += 2;
    if (pkt_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b exp 0", pkt_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", busy); end
    pkt_ready = 1'b1;
    repeat (10) tick();
    checks += 2;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL midrst_pkts got %0d exp 4", got_q.size());
    end
    if (done_cnt != 0) begin failures++; $display("FAIL midrst_done got %0d exp 0", done_cnt); end
    got_q.delete();
    load_all(1'b0);
    wait_done(100);
    check_full_sequence("reload");
  endtask

  task automatic test_small();
    int n = 0;
    s_got_q.delete();
    s_done_cnt   = 0;
    s_pkt_ready  = 1'b1;
    s_load_start = 1'b1;
    tick();
    s_load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_wr_valid = 1'b1;
      s_wr_addr  = 4'(i);
      s_wr_data  = 8'(i + 1);
      tick();
    end
    s_wr_valid  = 1'b0;
    s_load_done = 1'b1;
    tick();
    s_load_done = 1'b0;
    while (s_done_cnt == 0 && n < 60) begin
      tick();
      n++;
    end
    checks += 6;
    if (s_done_cnt == 0) begin failures++; $display("FAIL small_done got 0 exp 1"); end
    if (s_got_q.size() != 7) begin
      failures++; $display("FAIL small_count got %0d exp 7", s_got_q.size());
    end
    if (s_got_q[0] !== {4'd5, 4'd0, 25'h000201}) begin
      failures++; $display("FAIL small_p0 got %h exp %h", s_got_q[0], {4'd5, 4'd0, 25'h000201});
    end
    if (s_got_q[1] !== {4'd5, 4'd0, 25'h000003}) begin
      failures++; $display("FAIL small_p1 got %h exp %h", s_got_q[1], {4'd5, 4'd0, 25'h000003});
    end
    if (s_got_q[5] !== {4'd7, 4'd0, 25'h000009}) begin
      failures++; $display("FAIL small_p5 got %h exp %h", s_got_q[5], {4'd7, 4'd0, 25'h000009});
    end
    if (s_got_q[6] !== {4'd11, 4'd0, 25'd0}) begin
      failures++; $display("FAIL small_notify got %h exp %h", s_got_q[6], {4'd11, 4'd0, 25'd0});
    end
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; load_done = 1'b0;
    pkt_ready = 1'b0; ts_valid = 1'b0;
    s_load_start = 1'b0; s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_load_done = 1'b0; s_pkt_ready = 1'b0;
    test_reset();
`ifdef WMEM_REPLAY_EN
    test_replay_idle();
`endif
    test_basic();
`ifdef WMEM_REPLAY_EN
    test_replay();
`endif
    test_backpressure();
    test_same_cycle_done();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
